dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arb_sel.sv | 39 +++
 rtl/dmem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// The arbiter FSM state type, the number of requesting ports and the
// default abort limit for a memory access that never completes live here
// so that the top level and the grant selector agree on them.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin arbitration).
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Number of requesting ports.
   localparam int NUM_PORTS = 2;

   // Default number of WAIT cycles before an access is abandoned.
   localparam int DEFAULT_TIMEOUT = 16;

   // Width of the WAIT cycle counter; large enough for TIMEOUT up to 255.
   localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner selection for the data-memory arbiter.
// Purely combinational: turns the per-port request vector into a one-hot
// grant. With DMEM_ARB_RR_EN defined, a tie goes to the port that did not
// win last time; otherwise port 0 always wins and no history is needed.
module dmem_arb_sel
   import dmem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] i_req_valid,
`ifdef DMEM_ARB_RR_EN
   input  logic                 i_last_grant,
`endif
   output logic [NUM_PORTS-1:0] o_grant
);

`ifdef DMEM_ARB_RR_EN
   // Round-robin pick: a lone requester wins, a tie goes to the other port.
   always_comb begin
      o_grant = '0;
      if (i_req_valid == 2'b11) begin
         o_grant = i_last_grant ? 2'b01 : 2'b10;
      end else if (i_req_valid[0]) begin
         o_grant = 2'b01;
      end else if (i_req_valid[1]) begin
         o_grant = 2'b10;
      end
   end
`else
   // Fixed-priority pick: port 0 always beats port 1.
   always_comb begin
      o_grant = '0;
      if (i_req_valid[0]) begin
         o_grant = 2'b01;
      end else if (i_req_valid[1]) begin
         o_grant = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// Picks one of two requesters, launches a single memory access, waits for
// the memory (or gives up after TIMEOUT cycles) and returns a one-cycle
// completion pulse to the winner. Every output is registered, so a request
// sampled in IDLE sees mem_valid one cycle later and, with a memory that
// answers in the following cycle, req_ready three cycles later.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin instead of fixed
// priority; adds a last-grant register).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_rw,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        req_ready,
   output logic [1:0]        req_err,
   output logic [DATA_W-1:0] req_rdata,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [1:0]          r_grant;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mem_valid;
   logic                r_mem_rw;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [1:0]          r_req_ready;
   logic [1:0]          r_req_err;
   logic [DATA_W-1:0]   r_req_rdata;

   logic [1:0]          w_grant;
   logic                w_start;
   logic                w_timeout;
   logic                w_win_rw;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_wdata;

   logic [1:0]          w_grant_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_mem_valid_nxt;
   logic                w_mem_rw_nxt;
   logic [ADDR_W-1:0]   w_mem_addr_nxt;
   logic [DATA_W-1:0]   w_mem_wdata_nxt;
   logic [1:0]          w_req_ready_nxt;
   logic [1:0]          w_req_err_nxt;
   logic [DATA_W-1:0]   w_req_rdata_nxt;

`ifdef DMEM_ARB_RR_EN
   logic                r_last_grant;

   dmem_arb_sel u_sel (
      .i_req_valid  (req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );
`else
   dmem_arb_sel u_sel (
      .i_req_valid  (req_valid),
      .o_grant      (w_grant)
   );
`endif

   // A new access starts only when idle; requests at other times are ignored.
   assign w_start   = (r_state == IDLE) && (|req_valid);

   // The access is abandoned on the WAIT cycle that makes the count reach TIMEOUT.
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   assign w_win_rw    = w_grant[1] ? req_rw[1]  : req_rw[0];
   assign w_win_addr  = w_grant[1] ? req_addr1  : req_addr0;
   assign w_win_wdata = w_grant[1] ? req_wdata1 : req_wdata0;

   // State register; reset drops any in-flight access without a completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; memory completion and timeout both lead to the response cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_ready || w_timeout) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered memory request and response.
   always_comb begin
      w_grant_nxt     = r_grant;
      w_cnt_nxt       = r_cnt;
      w_mem_valid_nxt = r_mem_valid;
      w_mem_rw_nxt    = r_mem_rw;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_req_ready_nxt = '0;
      w_req_err_nxt   = '0;
      w_req_rdata_nxt = '0;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_grant_nxt     = w_grant;
               w_cnt_nxt       = '0;
               w_mem_valid_nxt = 1'b1;
               w_mem_rw_nxt    = w_win_rw;
               w_mem_addr_nxt  = w_win_addr;
               w_mem_wdata_nxt = w_win_wdata;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               w_mem_valid_nxt = 1'b0;
               w_req_ready_nxt = r_grant;
               w_req_rdata_nxt = r_mem_rw ? '0 : mem_rdata;
            end else if (w_timeout) begin
               w_mem_valid_nxt = 1'b0;
               w_req_ready_nxt = r_grant;
               w_req_err_nxt   = r_grant;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and response registers; everything clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant     <= '0;
         r_cnt       <= '0;
         r_mem_valid <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_req_ready <= '0;
         r_req_err   <= '0;
         r_req_rdata <= '0;
      end else begin
         r_grant     <= w_grant_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mem_valid <= w_mem_valid_nxt;
         r_mem_rw    <= w_mem_rw_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_req_err   <= w_req_err_nxt;
         r_req_rdata <= w_req_rdata_nxt;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Remember which port won most recently; reset favours port 0 next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (w_start) begin
         r_last_grant <= w_grant[1];
      end
   end
`endif

   assign req_ready = r_req_ready;
   assign req_err   = r_req_err;
   assign req_rdata = r_req_rdata;
   assign mem_valid = r_mem_valid;
   assign mem_rw    = r_mem_rw;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
